// File: rtl/sysid_check_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sysid_check_master: Avalon-MM read master that fetches the sysid ID and  |
// | timestamp words, compares them to build-time values, reports pass/fail.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sysid_check_master #(
  parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd0,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int          CW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] c_TMO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [31:0] c_TS_ADDR  = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_ID_REQ  = 3'd1,
    S_RD_ID_WAIT = 3'd2,
    S_RD_TS_REQ  = 3'd3,
    S_RD_TS_WAIT = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_read;
  logic [31:0]   r_addr;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic          r_id_match;
  logic          r_ts_match;
  logic          r_timeout;
  logic [31:0]   r_id_value;
  logic [31:0]   r_ts_value;
  logic [CW-1:0] r_cnt;

  state_t        w_state_nxt;
  logic          w_read_nxt;
  logic [31:0]   w_addr_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_pass_nxt;
  logic          w_id_match_nxt;
  logic          w_ts_match_nxt;
  logic          w_timeout_nxt;
  logic [31:0]   w_id_value_nxt;
  logic [31:0]   w_ts_value_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_tmo_hit;
  logic          w_abort;
  logic          w_id_eq;
  logic          w_ts_eq;

  // A zero TIMEOUT_CYCLES freezes the counter and never fires.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == c_TMO_LAST);
  assign w_cnt_inc = (TIMEOUT_CYCLES != 0) ? (r_cnt + CW'(1)) : r_cnt;
  assign w_id_eq   = (avm_readdata == EXPECTED_ID);
  assign w_ts_eq   = (avm_readdata == EXPECTED_TIMESTAMP);

  always_comb begin
    w_state_nxt    = r_state;
    w_read_nxt     = r_read;
    w_addr_nxt     = r_addr;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_pass_nxt     = r_pass;
    w_id_match_nxt = r_id_match;
    w_ts_match_nxt = r_ts_match;
    w_timeout_nxt  = r_timeout;
    w_id_value_nxt = r_id_value;
    w_ts_value_nxt = r_ts_value;
    w_cnt_nxt      = r_cnt;
    w_abort        = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt    = S_RD_ID_REQ;
          w_read_nxt     = 1'b1;
          w_addr_nxt     = BASE_ADDR;
          w_busy_nxt     = 1'b1;
          w_done_nxt     = 1'b0;
          w_pass_nxt     = 1'b0;
          w_id_match_nxt = 1'b0;
          w_ts_match_nxt = 1'b0;
          w_timeout_nxt  = 1'b0;
          w_cnt_nxt      = '0;
        end
      end
      S_RD_ID_REQ: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_tmo_hit) begin
          w_abort = 1'b1;
        end else if (!avm_waitrequest) begin
          w_read_nxt  = 1'b0;
          w_state_nxt = S_RD_ID_WAIT;
        end
      end
      S_RD_ID_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        // Completion takes priority over an expiring timeout.
        if (avm_readdatavalid) begin
          w_id_value_nxt = avm_readdata;
          w_id_match_nxt = w_id_eq;
          w_read_nxt     = 1'b1;
          w_addr_nxt     = c_TS_ADDR;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_RD_TS_REQ;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      S_RD_TS_REQ: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_tmo_hit) begin
          w_abort = 1'b1;
        end else if (!avm_waitrequest) begin
          w_read_nxt  = 1'b0;
          w_state_nxt = S_RD_TS_WAIT;
        end
      end
      S_RD_TS_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (avm_readdatavalid) begin
          w_ts_value_nxt = avm_readdata;
          w_ts_match_nxt = w_ts_eq;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
          w_pass_nxt     = r_id_match & w_ts_eq;
          w_state_nxt    = S_DONE;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Timed-out read: drop the request and finish with the flags seen so far.
    if (w_abort) begin
      w_read_nxt    = 1'b0;
      w_timeout_nxt = 1'b1;
      w_pass_nxt    = 1'b0;
      w_done_nxt    = 1'b1;
      w_busy_nxt    = 1'b0;
      w_state_nxt   = S_DONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_read     <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_read     <= w_read_nxt;
      r_addr     <= w_addr_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_id_match <= w_id_match_nxt;
      r_ts_match <= w_ts_match_nxt;
      r_timeout  <= w_timeout_nxt;
      r_id_value <= w_id_value_nxt;
      r_ts_value <= w_ts_value_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign id_match    = r_id_match;
  assign ts_match    = r_ts_match;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule
`default_nettype wire

// File: tb/tb_sysid_check_master.sv
`default_nettype none
// Directed bench for sysid_check_master: behavioural sysid slave, address and
// result scoreboards, cycle-accurate checks of the request/response timing.
module tb_sysid_check_master;

  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam logic [31:0] TS_ADDR = BASE + 32'd4;
  localparam logic [31:0] EXP_ID  = 32'h58F9_3F21;
  localparam logic [31:0] EXP_TS  = 32'h5EE1_0000;
  localparam int          TO      = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, pass, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;

  sysid_check_master #(
    .BASE_ADDR          (BASE),
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_match          (id_match),
    .ts_match          (ts_match),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboards ----------------
  typedef struct {
    int          dcyc;
    logic        p, idm, tsm, tmo;
    logic [31:0] idv, tsv;
  } res_t;

  res_t        res_q[$];
  logic [31:0] addr_q[$];
  int          n_done = 0;

  task automatic push_res(input int dc, input logic p, input logic idm, input logic tsm,
                          input logic tmo, input logic [31:0] idv, input logic [31:0] tsv);
    res_t r;
    r.dcyc = dc; r.p = p; r.idm = idm; r.tsm = tsm; r.tmo = tmo; r.idv = idv; r.tsv = tsv;
    res_q.push_back(r);
  endtask

  // ---------------- behavioural sysid slave ----------------
  int          stall_left = 0;
  int          lat = 1;
  int          pend = 0;
  logic        pend_drop = 1'b0;
  logic [31:0] pend_data = '0;
  logic [31:0] data_id = EXP_ID;
  logic [31:0] data_ts = EXP_TS;
  logic        drop_ts = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] stray_data = '0;
  int          n_acc = 0;

  initial begin
    logic [31:0] ea;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clock);
      #2;
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !pend_drop) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      if (stray) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = stray_data;
        stray             = 1'b0;
      end
      if (avm_read === 1'b1) begin
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          n_acc++;
          ea = 32'hxxxx_xxxx;
          if (addr_q.size() != 0) ea = addr_q.pop_front();
          check("acc_addr", avm_address, ea);
          pend      = lat;
          pend_drop = drop_ts && (avm_address == TS_ADDR);
          pend_data = (avm_address == BASE) ? data_id : data_ts;
        end
      end
    end
  end

  // ---------------- result monitor ----------------
  initial begin
    logic done_q;
    res_t r;
    done_q = 1'b0;
    forever begin
      @(negedge clock);
      if (done === 1'b1 && done_q !== 1'b1) begin
        n_done++;
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          check("res_cycle", cyc, r.dcyc);
          check("res_pass", pass, r.p);
          check("res_id_match", id_match, r.idm);
          check("res_ts_match", ts_match, r.tsm);
          check("res_timeout", timeout, r.tmo);
          check("res_id_value", id_value, r.idv);
          check("res_ts_value", ts_value, r.tsv);
        end else begin
          check("res_unexpected_done", cyc, 32'hxxxx_xxxx);
        end
      end
      done_q = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clock);
  endtask

  task automatic pulse(input int c);
    goto(c);
    start = 1'b1;
    goto(c + 1);
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, {avm_read, busy, done, pass, id_match, ts_match, timeout}, 32'd0);
    check({tag, "_addr"}, avm_address, BASE);
    check({tag, "_id_value"}, id_value, 32'd0);
    check({tag, "_ts_value"}, ts_value, 32'd0);
  endtask

  initial begin
    int s;
    int acc0;
    reset = 1'b1;
    start = 1'b0;
    at_neg(2);
    check_reset("reset");
    goto(3);
    reset = 1'b0;

    // Nominal: zero-wait slave, latency 1.
    s = 5;
    addr_q.push_back(BASE); addr_q.push_back(TS_ADDR);
    push_res(s + 5, 1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
    pulse(s);
    for (int k = 1; k <= 5; k++) begin
      at_neg(s + k);
      check("t1_busy", busy, (k <= 4));
      check("t1_read", avm_read, (k == 1 || k == 3));
      if (k == 1) check("t1_addr_id", avm_address, BASE);
      if (k == 3) check("t1_addr_ts", avm_address, TS_ADDR);
      check("t1_done", done, (k == 5));
    end

    // Waitrequest held three cycles on the ID read.
    s = 20;
    stall_left = 3;
    acc0 = n_acc;
    addr_q.push_back(BASE); addr_q.push_back(TS_ADDR);
    push_res(s + 8, 1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
    pulse(s);
    for (int k = 1; k <= 4; k++) begin
      at_neg(s + k);
      check("t2_read_held", avm_read, 32'd1);
      check("t2_addr_held", avm_address, BASE);
    end
    at_neg(s + 5);
    check("t2_read_drop", avm_read, 32'd0);
    at_neg(s + 8);
    check("t2_done", done, 32'd1);
    check("t2_accepts", n_acc - acc0, 32'd2);

    // Timestamp read never answered: timeout 8 cycles after its request.
    s = 40;
    drop_ts = 1'b1;
    addr_q.push_back(BASE); addr_q.push_back(TS_ADDR);
    push_res(s + 11, 1'b0, 1'b1, 1'b0, 1'b1, EXP_ID, EXP_TS);
    pulse(s);
    at_neg(s + 10);
    check("t3_pre_tmo", {done, busy, timeout}, 32'b010);
    at_neg(s + 11);
    check("t3_tmo", {avm_read, busy, done, timeout}, 32'b0011);
    goto(s + 12);
    stray_data = 32'h0;
    stray      = 1'b1;
    drop_ts    = 1'b0;
    at_neg(s + 13);
    check("t3_late_ts_value", ts_value, EXP_TS);
    check("t3_late_flags", {done, pass, timeout, busy, ts_match}, 32'b10100);

    // Timestamp mismatch.
    s = 60;
    data_ts = 32'h0;
    addr_q.push_back(BASE); addr_q.push_back(TS_ADDR);
    push_res(s + 5, 1'b0, 1'b1, 1'b0, 1'b0, EXP_ID, 32'h0);
    pulse(s);
    at_neg(s + 5);
    check("t4_flags", {id_match, ts_match, pass, done}, 32'b1001);
    data_ts = EXP_TS;

    // Starts while busy are ignored; a start after done reruns the check.
    s = 80;
    addr_q.push_back(BASE); addr_q.push_back(TS_ADDR);
    push_res(s + 5, 1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
    pulse(s);
    pulse(s + 2);
    pulse(s + 4);
    at_neg(s + 6);
    check("t5_still_done", {busy, done, avm_read}, 32'b010);
    addr_q.push_back(BASE); addr_q.push_back(TS_ADDR);
    push_res(s + 12, 1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
    pulse(s + 7);
    at_neg(s + 8);
    check("t5_restart_flags", {busy, done, pass, id_match, ts_match, timeout}, 32'b100000);
    check("t5_restart_read", avm_read, 32'd1);
    check("t5_keep_ts_value", ts_value, EXP_TS);
    at_neg(s + 12);
    check("t5_rerun_pass", {done, pass}, 32'b11);

    // Reset while waiting for the ID data; the late readdatavalid is ignored.
    s = 100;
    lat = 3;
    addr_q.push_back(BASE);
    pulse(s);
    goto(s + 2);
    reset = 1'b1;
    goto(s + 3);
    reset = 1'b0;
    at_neg(s + 3);
    check_reset("midrst");
    at_neg(s + 5);
    check_reset("stray");
    at_neg(s + 6);
    check("t6_no_request", avm_read, 32'd0);
    lat = 1;

    at_neg(s + 10);
    check("addr_q_left", addr_q.size(), 32'd0);
    check("res_q_left", res_q.size(), 32'd0);
    check("done_events", n_done, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
